// File: rtl/uart_xintf_pkg.sv
// Shared constants, state types and zone decode for the UART-to-XINTF bridge.
package uart_xintf_pkg;
  localparam logic [7:0] CMD_WRITE  = 8'h77;
  localparam logic [7:0] CMD_READ   = 8'h72;
  localparam logic [7:0] ZONE6_CODE = 8'h01;
  localparam logic [7:0] ZONE7_CODE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_BUS, ST_SEND_HI, ST_SEND_LO
  } parser_state_t;

  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

  // Returns {zone7_select, zone6_select}; at most one bit can be set.
  function automatic logic [1:0] zone_sel(input logic [7:0] code);
    return {code == ZONE7_CODE, code == ZONE6_CODE};
  endfunction
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, one-cycle o_valid per good byte.
module uart_rx
  import uart_xintf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t   r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx;

  assign w_rx = r_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      o_valid <= 1'b0;
      case (r_state)
        UART_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rx) r_state <= UART_START;
        end
        UART_START:
          if (r_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            r_cnt   <= '0;
            r_state <= w_rx ? UART_IDLE : UART_DATA;
          end else r_cnt <= r_cnt + CW'(1);
        UART_DATA:
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= UART_STOP;
          end else r_cnt <= r_cnt + CW'(1);
        UART_STOP:
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_state <= UART_IDLE;
            if (w_rx) begin
              o_data  <= r_shift;
              o_valid <= 1'b1;
            end
          end else r_cnt <= r_cnt + CW'(1);
        default: r_state <= UART_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a one-cycle i_start launches i_data; o_busy covers the whole frame.
module uart_tx
  import uart_xintf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      case (r_state)
        UART_IDLE: begin
          o_tx <= 1'b1;
          if (i_start) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            o_tx    <= 1'b0;
            o_busy  <= 1'b1;
            r_state <= UART_START;
          end
        end
        UART_START:
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            o_tx    <= r_shift[0];
            r_state <= UART_DATA;
          end else r_cnt <= r_cnt + CW'(1);
        UART_DATA:
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
            o_tx    <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            if (r_bit == 3'd7) r_state <= UART_STOP;
          end else r_cnt <= r_cnt + CW'(1);
        UART_STOP:
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            o_busy  <= 1'b0;
            r_state <= UART_IDLE;
          end else r_cnt <= r_cnt + CW'(1);
        default: r_state <= UART_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/xintf_translate.sv
// Frame parser, fixed-timing XINTF bus cycle and two-byte read response sequencing.
module xintf_translate
  import uart_xintf_pkg::*;
#(
  parameter int XWAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic [15:0] o_xa,
  output logic [15:0] o_xd,
  output logic        o_xd_oe,
  input  logic [15:0] i_xd,
  output logic        o_xwen,
  output logic        o_xrdn,
  output logic        o_zone_6_n,
  output logic        o_zone_7_n
);
  localparam int BW = $clog2(XWAIT + 3);

  parser_state_t r_state;
  logic          r_is_write, r_zone_ok;
  logic [31:0]   r_addr;
  logic [15:0]   r_wdata, r_data_tx_1;
  logic [1:0]    r_cnt;
  logic [BW-1:0] r_bus_cnt;
  logic [31:0]   w_addr_next;
  logic [7:0]    w_zone_code;
  logic [15:0]   w_bus_xa;
  logic [1:0]    w_sel;
  logic          w_enter_bus;

  // A read enters the bus straight from the last address byte, so decode the not-yet-stored address.
  // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
  always_comb begin
    w_addr_next = {r_addr[23:0], i_rx_data};
    w_zone_code = (r_state == ST_ADDR) ? r_addr[23:16] : r_addr[31:24];
    w_bus_xa    = (r_state == ST_ADDR) ? w_addr_next[15:0] : r_addr[15:0];
    w_sel       = zone_sel(w_zone_code);
    w_enter_bus = i_rx_valid && ((r_state == ST_ADDR && r_cnt == 2'd3 && !r_is_write) ||
                                 (r_state == ST_DATA && r_cnt == 2'd1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_zone_ok   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_data_tx_1 <= '0;
      r_cnt       <= '0;
      r_bus_cnt   <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_xa        <= '0;
      o_xd        <= '0;
      o_xd_oe     <= 1'b0;
      o_xwen      <= 1'b1;
      o_xrdn      <= 1'b1;
      o_zone_6_n  <= 1'b1;
      o_zone_7_n  <= 1'b1;
    end else begin
      o_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (i_rx_valid && (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ)) begin
            r_is_write <= (i_rx_data == CMD_WRITE);
            r_state    <= ST_CMD;
          end
        ST_CMD: begin
          r_cnt   <= '0;
          r_state <= ST_ADDR;
        end
        ST_ADDR:
          if (i_rx_valid) begin
            r_addr <= w_addr_next;
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3 && r_is_write) r_state <= ST_DATA;
          end
        ST_DATA:
          if (i_rx_valid) begin
            r_wdata <= {r_wdata[7:0], i_rx_data};
            r_cnt   <= r_cnt + 2'd1;
          end
        ST_BUS: begin
          r_bus_cnt <= r_bus_cnt + BW'(1);
          if (r_bus_cnt == BW'(XWAIT)) begin
            o_xwen  <= 1'b1;
            o_xrdn  <= 1'b1;
            o_xd_oe <= 1'b0;
            if (!r_is_write) r_data_tx_1 <= r_zone_ok ? i_xd : 16'h0000;
          end else if (r_bus_cnt == BW'(XWAIT + 1)) begin
            o_zone_6_n <= 1'b1;
            o_zone_7_n <= 1'b1;
            r_state    <= r_is_write ? ST_IDLE : ST_SEND_HI;
          end else if (r_zone_ok) begin
            o_xwen  <= !r_is_write;
            o_xrdn  <= r_is_write;
            o_xd_oe <= r_is_write;
          end
        end
        // o_tx_start gates the launch so the busy flag has a cycle to rise before the next byte.
        ST_SEND_HI:
          if (!i_tx_busy && !o_tx_start) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= r_data_tx_1[15:8];
            r_state    <= ST_SEND_LO;
          end
        ST_SEND_LO:
          if (!i_tx_busy && !o_tx_start) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= r_data_tx_1[7:0];
            r_state    <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
      if (w_enter_bus) begin
        r_state    <= ST_BUS;
        r_bus_cnt  <= '0;
        o_xa       <= w_bus_xa;
        o_xd       <= {r_wdata[7:0], i_rx_data};
        o_zone_6_n <= !w_sel[0];
        o_zone_7_n <= !w_sel[1];
        r_zone_ok  <= |w_sel;
      end
    end
  end
endmodule

// File: rtl/uart_xintf_bridge.sv
// UART-to-XINTF bridge top: UART receive/transmit around the frame parser and bus sequencer.
module uart_xintf_bridge #(
  parameter int INPUT_CLK = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int XWAIT     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] xa,
  inout  wire  [15:0] xd,
  output logic        xwen,
  output logic        xrdn,
  output logic        zone_6_n,
  output logic        zone_7_n,
  input  logic        xready
);
  localparam int CLKS_PER_BIT = INPUT_CLK / BAUD_RATE;

  logic [7:0]  w_rx_data, w_tx_data;
  logic        w_rx_valid, w_tx_start, w_tx_busy, w_xd_oe;
  logic [15:0] w_xd_out;
  logic        w_unused_xready;

  // Bus timing is fixed by XWAIT; xready is accepted only for pin compatibility.
  assign w_unused_xready = xready;
  assign xd = w_xd_oe ? w_xd_out : 16'hzzzz;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .i_clk(clk), .i_rst(reset), .i_rx(RX), .o_data(w_rx_data), .o_valid(w_rx_valid)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .i_clk(clk), .i_rst(reset), .i_start(w_tx_start), .i_data(w_tx_data),
    .o_tx(TX), .o_busy(w_tx_busy)
  );

  xintf_translate #(.XWAIT(XWAIT)) xintf_translate (
    .i_clk(clk), .i_rst(reset), .i_rx_data(w_rx_data), .i_rx_valid(w_rx_valid),
    .i_tx_busy(w_tx_busy), .o_tx_start(w_tx_start), .o_tx_data(w_tx_data),
    .o_xa(xa), .o_xd(w_xd_out), .o_xd_oe(w_xd_oe), .i_xd(xd),
    .o_xwen(xwen), .o_xrdn(xrdn), .o_zone_6_n(zone_6_n), .o_zone_7_n(zone_7_n)
  );
endmodule

// File: tb/tb_uart_xintf_bridge.sv
// Scoreboard bench for uart_xintf_bridge: serial frames in, bus cycles and TX bytes checked.
module tb_uart_xintf_bridge;
  localparam int INPUT_CLK = 1000;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = 10;
  localparam int XWAIT     = 4;
  localparam logic [15:0] PARK = 16'hC3C3;

  typedef struct {
    logic        is_write;
    logic        z6;
    logic        z7;
    logic [15:0] xa;
    logic [15:0] xd;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RX = 1'b1;
  logic        xready = 1'b1;
  logic        TX, xwen, xrdn, zone_6_n, zone_7_n;
  logic [15:0] xa;
  wire  [15:0] xd;
  logic [15:0] rd_val = 16'h0000;

  bus_exp_t    bus_q[$];
  logic [7:0]  tx_q[$];
  int          n_pass = 0;
  int          n_checks = 0;
  int          zone_cycles = 0;

  // External device: parks a known pattern on xd whenever the bridge is not write-strobing,
  // and returns rd_val while xrdn is low. A bridge that fails to release xd corrupts PARK.
  assign xd = xwen ? (xrdn ? PARK : rd_val) : 16'hzzzz;

  uart_xintf_bridge #(.INPUT_CLK(INPUT_CLK), .BAUD_RATE(BAUD_RATE), .XWAIT(XWAIT)) dut (
    .clk(clk), .reset(reset), .RX(RX), .TX(TX), .xa(xa), .xd(xd), .xwen(xwen), .xrdn(xrdn),
    .zone_6_n(zone_6_n), .zone_7_n(zone_7_n), .xready(xready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void expect_bus(input logic w, input logic [31:0] addr, input logic [15:0] d);
    bus_exp_t e;
    if (addr[31:24] == 8'h01 || addr[31:24] == 8'h02) begin
      e.is_write = w;
      e.z6 = (addr[31:24] == 8'h01);
      e.z7 = (addr[31:24] == 8'h02);
      e.xa = addr[15:0];
      e.xd = d;
      bus_q.push_back(e);
    end
  endfunction

  task automatic send_bits(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_stop();
    RX = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    send_stop();
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [15:0] data);
    expect_bus(1'b1, addr, data);
    send_byte(8'h77);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic send_read(input logic [31:0] addr, input logic [15:0] ext, input logic [15:0] resp);
    expect_bus(1'b0, addr, 16'h0000);
    rd_val = ext;
    tx_q.push_back(resp[15:8]);
    tx_q.push_back(resp[7:0]);
    send_byte(8'h72);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
  endtask

  task automatic wait_drain(input string tag);
    int i = 0;
    while ((bus_q.size() != 0 || tx_q.size() != 0) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_bus_drained"}, bus_q.size(), 0);
    check({tag, "_tx_drained"}, tx_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  // Bus monitor: captures each strobe window and compares it against the scoreboard.
  int          strobe_len = 0;
  logic        cap_write, cap_z6, cap_z7;
  logic [15:0] cap_xa, cap_xd;
  always @(negedge clk) begin
    bus_exp_t e;
    if (reset) strobe_len = 0;
    else begin
      if (!zone_6_n || !zone_7_n) zone_cycles++;
      if (!xwen || !xrdn) begin
        if (strobe_len == 0) begin
          cap_write = !xwen;
          cap_xa = xa;
          cap_z6 = !zone_6_n;
          cap_z7 = !zone_7_n;
          cap_xd = xd;
          check("strobe_exclusive", {31'd0, xwen | xrdn}, 1);
        end
        strobe_len++;
      end else if (strobe_len != 0) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          e = bus_q.pop_front();
          check("bus_kind_write", cap_write, e.is_write);
          check("bus_xa", cap_xa, e.xa);
          check("bus_zone6", cap_z6, e.z6);
          check("bus_zone7", cap_z7, e.z7);
          if (e.is_write) check("bus_xd", cap_xd, e.xd);
          check("strobe_len", strobe_len, XWAIT);
          check("xd_released", xd, PARK);
          check("zone_held_after_strobe", {zone_7_n, zone_6_n}, {!e.z7, !e.z6});
        end
        strobe_len = 0;
      end
    end
  end

  // TX monitor: decodes 8N1 frames at mid-bit and compares against the scoreboard.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TX);
      if (!reset) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = TX;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", TX, 1);
        if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_byte", b, tx_q.pop_front());
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx", TX, 1);
    check("rst_xwen", xwen, 1);
    check("rst_xrdn", xrdn, 1);
    check("rst_zone6", zone_6_n, 1);
    check("rst_zone7", zone_7_n, 1);
    check("rst_xa", xa, 0);
    check("rst_xd_released", xd, PARK);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    zone_cycles = 0;
    send_write(32'h0100_1000, 16'h0AA0);
    wait_drain("write_z6");
    check("write_z6_zone_cycles", zone_cycles, XWAIT + 2);

    zone_cycles = 0;
    send_read(32'h0100_1000, 16'h1234, 16'h1234);
    wait_drain("read_z6");
    check("read_z6_zone_cycles", zone_cycles, XWAIT + 2);

    // data_tx_1 overridden after the last address byte: the value at launch time goes out.
    expect_bus(1'b0, 32'h0100_2000, 16'h0000);
    rd_val = 16'h5A5A;
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    send_byte(8'h72);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h20);
    send_bits(8'h00);
    force dut.xintf_translate.r_data_tx_1 = 16'hBEEF;
    send_stop();
    wait_drain("read_forced");
    release dut.xintf_translate.r_data_tx_1;

    zone_cycles = 0;
    send_write(32'h0200_0004, 16'h55AA);
    wait_drain("write_z7");
    check("write_z7_zone_cycles", zone_cycles, XWAIT + 2);

    zone_cycles = 0;
    send_write(32'h0300_0000, 16'h1122);
    wait_drain("write_badzone");
    check("write_badzone_zone_cycles", zone_cycles, 0);

    zone_cycles = 0;
    send_read(32'h0500_0000, 16'hFFFF, 16'h0000);
    wait_drain("read_badzone");
    check("read_badzone_zone_cycles", zone_cycles, 0);

    send_byte(8'h41);
    send_write(32'h0100_0020, 16'hC0DE);
    wait_drain("garbage_then_write");

    // Reset while the write strobe is low; this frame is deliberately not scoreboarded.
    send_byte(8'h77);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h11);
    send_bits(8'h11);
    RX = 1'b1;
    i = 0;
    while (xwen && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("reset_test_strobe_seen", !xwen, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_xwen", xwen, 1);
    check("midrst_xrdn", xrdn, 1);
    check("midrst_zone6", zone_6_n, 1);
    check("midrst_zone7", zone_7_n, 1);
    check("midrst_tx", TX, 1);
    check("midrst_xd_released", xd, PARK);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    zone_cycles = 0;
    send_write(32'h0100_0040, 16'h2222);
    wait_drain("after_reset_write");
    check("after_reset_zone_cycles", zone_cycles, XWAIT + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
